// File: rtl/vect_mem_stage.sv
// Vector memory stage: passes ALU results straight to writeback, or serialises a
// vector load/store one lane per cycle over a single-word synchronous data memory.
module vect_mem_stage #(
    parameter int unsigned N      = 24,
    parameter int unsigned LANES  = 2,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 validIn,
    input  logic                 memWrite,
    input  logic                 memToReg,
    input  logic                 regWrite,
    input  logic [3:0]           rdIn,
    input  logic [LANES*N-1:0]   aluResult,
    input  logic [LANES*N-1:0]   storeData,
    output logic                 stall,
    output logic [ADDR_W-1:0]    memAddr,
    output logic                 memWe,
    output logic [N-1:0]         memWdata,
    input  logic [N-1:0]         memRdata,
    output logic                 wbValid,
    output logic                 wbRegWrite,
    output logic [3:0]           wbRd,
    output logic [LANES*N-1:0]   wbData,
    output logic [LANES*N-1:0]   forwardOut
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VEC_W = LANES * N;
    localparam int          LANE_W = int'(N);
    localparam int          LAST_LANE = int'(LANES) - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   base_q;
    logic [VEC_W-1:0]    sdata_q;
    logic [3:0]          rd_q;
    logic                rw_q;
    logic                store_q;
    logic                wb_valid_q;
    logic                wb_rw_q;
    logic [3:0]          wb_rd_q;
    logic [VEC_W-1:0]    wb_data_q;

    // Memory port is a pure decode of the registered state so reset clears it at once.
    always_comb begin
        stall    = (state_q != IDLE);
        memAddr  = '0;
        memWe    = 1'b0;
        memWdata = '0;
        if (state_q == ACCESS) begin
            memAddr = base_q + ADDR_W'(idx_q);
            memWe   = store_q;
            if (store_q) begin
                memWdata = sdata_q[int'(idx_q) * LANE_W +: N];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            base_q     <= '0;
            sdata_q    <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            store_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (validIn) begin
                        if (memWrite || memToReg) begin
                            // A store wins when both flags are set.
                            base_q  <= aluResult[ADDR_W-1:0];
                            sdata_q <= storeData;
                            rd_q    <= rdIn;
                            rw_q    <= regWrite;
                            store_q <= memWrite;
                            idx_q   <= '0;
                            state_q <= ACCESS;
                        end else begin
                            wb_data_q  <= aluResult;
                            wb_rd_q    <= rdIn;
                            wb_rw_q    <= regWrite;
                            wb_valid_q <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // Read data trails its address by one cycle, so lane idx-1 lands now.
                    if (!store_q && (idx_q != '0)) begin
                        wb_data_q[(int'(idx_q) - 1) * LANE_W +: N] <= memRdata;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= FINISH;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                FINISH: begin
                    if (!store_q) begin
                        wb_data_q[LAST_LANE * LANE_W +: N] <= memRdata;
                    end
                    wb_rd_q    <= rd_q;
                    wb_rw_q    <= rw_q & ~store_q;
                    wb_valid_q <= 1'b1;
                    idx_q      <= '0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wbValid    = wb_valid_q;
    assign wbRegWrite = wb_rw_q;
    assign wbRd       = wb_rd_q;
    assign wbData     = wb_data_q;
    assign forwardOut = wb_data_q;

endmodule

// File: tb/tb_vect_mem_stage.sv
// Directed bench for vect_mem_stage: table of pass-through/load/store vectors against a
// bench-side word memory, plus back-to-back and reset-during-store sequences.
module tb_vect_mem_stage;

    localparam int N     = 24;
    localparam int LANES = 2;
    localparam int AW    = 16;

    logic            clk;
    logic            rst;
    logic            validIn, memWrite, memToReg, regWrite;
    logic [3:0]      rdIn;
    logic [47:0]     aluResult, storeData;
    logic            stall;
    logic [AW-1:0]   memAddr;
    logic            memWe;
    logic [N-1:0]    memWdata;
    logic [N-1:0]    memRdata;
    logic            wbValid, wbRegWrite;
    logic [3:0]      wbRd;
    logic [47:0]     wbData, forwardOut;

    int errors = 0;
    int checks = 0;

    vect_mem_stage #(.N(N), .LANES(LANES), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .validIn(validIn), .memWrite(memWrite),
        .memToReg(memToReg), .regWrite(regWrite), .rdIn(rdIn),
        .aluResult(aluResult), .storeData(storeData), .stall(stall),
        .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata),
        .memRdata(memRdata), .wbValid(wbValid), .wbRegWrite(wbRegWrite),
        .wbRd(wbRd), .wbData(wbData), .forwardOut(forwardOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side synchronous data memory with a preload port.
    logic [N-1:0]  mem [0:65535];
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [N-1:0]  tb_data;
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (memWe) mem[memAddr] <= memWdata;
        memRdata <= mem[memAddr];
    end

    typedef struct {
        logic        we;
        logic        ld;
        logic [47:0] alu;
        logic [47:0] sd;
        logic [3:0]  rd;
        logic        rw;
        logic [47:0] exp_data;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [N-1:0] d);
        tb_addr = a; tb_data = d; tb_we = 1'b1;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        validIn = 1'b1; memWrite = v.we; memToReg = v.ld; regWrite = v.rw;
        rdIn = v.rd; aluResult = v.alu; storeData = v.sd;
    endtask

    // Applies one instruction from a negedge and follows it to its writeback pulse.
    task automatic run_vec(input vec_t v, input int id);
        bit done;
        int stalls;
        int exp_lat;
        int exp_stalls;
        logic [AW-1:0] ea;
        logic mem_op;
        mem_op = v.we | v.ld;
        exp_lat = mem_op ? LANES + 2 : 1;
        exp_stalls = mem_op ? LANES + 1 : 0;
        done = 1'b0;
        stalls = 0;
        drive(v);
        for (int c = 1; c <= 12 && !done; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (mem_op && c <= LANES) begin
                ea = v.alu[AW-1:0] + AW'(c - 1);
                chk($sformatf("v%0d addr c%0d", id, c), 64'(memAddr), 64'(ea));
                chk($sformatf("v%0d we c%0d", id, c), 64'(memWe), 64'(v.we));
                if (v.we) chk($sformatf("v%0d wdata c%0d", id, c), 64'(memWdata), 64'(v.sd[(c-1)*N +: N]));
            end
            if (wbValid) begin
                done = 1'b1;
                validIn = 1'b0;
                chk($sformatf("v%0d latency", id), 64'(c), 64'(exp_lat));
                chk($sformatf("v%0d stall cycles", id), 64'(stalls), 64'(exp_stalls));
                chk($sformatf("v%0d wbData", id), 64'(wbData), 64'(v.exp_data));
                chk($sformatf("v%0d forwardOut", id), 64'(forwardOut), 64'(v.exp_data));
                chk($sformatf("v%0d wbRd", id), 64'(wbRd), 64'(v.rd));
                chk($sformatf("v%0d wbRegWrite", id), 64'(wbRegWrite), 64'(v.exp_rw));
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL v%0d timeout: no wbValid within 12 cycles", id);
            validIn = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("v%0d wbValid single pulse", id), 64'(wbValid), 64'd0);
    endtask

    initial begin
        bit done;
        int c;
        vec_t v;

        // {lane1, lane0} packing throughout.
        vecs[0] = '{1'b0, 1'b0, {24'd2, 24'd1}, 48'd0, 4'd3, 1'b1, {24'd2, 24'd1}, 1'b1};
        vecs[1] = '{1'b0, 1'b0, {24'hFFFFFF, 24'hABCDEF}, 48'd0, 4'd15, 1'b0, {24'hFFFFFF, 24'hABCDEF}, 1'b0};
        vecs[2] = '{1'b0, 1'b1, {24'h000777, 24'hAB0010}, 48'd0, 4'd5, 1'b1, {24'd12, 24'd11}, 1'b1};
        vecs[3] = '{1'b1, 1'b0, {24'd0, 24'h000020}, {24'd10, 24'd9}, 4'd7, 1'b1, {24'd12, 24'd11}, 1'b0};
        vecs[4] = '{1'b0, 1'b1, {24'd0, 24'h00FFFF}, 48'd0, 4'd2, 1'b1, {24'h222222, 24'h111111}, 1'b1};
        vecs[5] = '{1'b1, 1'b1, {24'd0, 24'h000030}, {24'h0A0B0C, 24'h010203}, 4'd4, 1'b1, {24'h222222, 24'h111111}, 1'b0};
        vecs[6] = '{1'b0, 1'b1, {24'd0, 24'h000020}, 48'd0, 4'd6, 1'b1, {24'd10, 24'd9}, 1'b1};
        vecs[7] = '{1'b0, 1'b1, {24'd0, 24'h000030}, 48'd0, 4'd8, 1'b1, {24'h0A0B0C, 24'h010203}, 1'b1};
        vecs[8] = '{1'b0, 1'b0, {24'h00BEEF, 24'h00CAFE}, 48'd0, 4'd1, 1'b1, {24'h00BEEF, 24'h00CAFE}, 1'b1};

        rst = 1'b0; validIn = 1'b0; memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0;
        rdIn = '0; aluResult = '0; storeData = '0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        repeat (2) @(negedge clk);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset memWe", 64'(memWe), 64'd0);
        chk("reset memAddr", 64'(memAddr), 64'd0);
        chk("reset wbValid", 64'(wbValid), 64'd0);
        chk("reset wbData", 64'(wbData), 64'd0);
        chk("reset wbRd", 64'(wbRd), 64'd0);
        rst = 1'b1;
        poke(16'h0010, 24'd11);
        poke(16'h0011, 24'd12);
        poke(16'hFFFF, 24'h111111);
        poke(16'h0000, 24'h222222);
        poke(16'h0040, 24'h000000);
        poke(16'h0041, 24'h123456);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Load followed by a pass-through that upstream holds while stalled.
        v = vecs[2];
        drive(v);
        @(negedge clk);
        v = vecs[8];
        drive(v);
        done = 1'b0;
        c = 1;
        while (!done && c < 12) begin
            @(negedge clk);
            c++;
            if (wbValid) done = 1'b1;
        end
        chk("b2b load latency", 64'(c), 64'd4);
        chk("b2b load wbData", 64'(wbData), {16'd0, 24'd12, 24'd11});
        chk("b2b load wbRd", 64'(wbRd), 64'd5);
        @(negedge clk);
        validIn = 1'b0;
        chk("b2b pass wbValid", 64'(wbValid), 64'd1);
        chk("b2b pass stall", 64'(stall), 64'd0);
        chk("b2b pass wbData", 64'(wbData), {16'd0, 24'h00BEEF, 24'h00CAFE});
        chk("b2b pass wbRd", 64'(wbRd), 64'd1);
        @(negedge clk);
        chk("b2b after pulse", 64'(wbValid), 64'd0);

        // Reset asserted during the lane-1 cycle of a store.
        v = '{1'b1, 1'b0, {24'd0, 24'h000040}, {24'h0000BB, 24'h0000AA}, 4'd9, 1'b1, 48'd0, 1'b0};
        drive(v);
        @(negedge clk);
        chk("rst-op lane0 we", 64'(memWe), 64'd1);
        @(negedge clk);
        chk("rst-op lane1 we", 64'(memWe), 64'd1);
        chk("rst-op lane1 addr", 64'(memAddr), 64'h41);
        rst = 1'b0;
        #1;
        chk("rst-op memWe", 64'(memWe), 64'd0);
        chk("rst-op stall", 64'(stall), 64'd0);
        chk("rst-op memAddr", 64'(memAddr), 64'd0);
        chk("rst-op memWdata", 64'(memWdata), 64'd0);
        chk("rst-op wbData", 64'(wbData), 64'd0);
        chk("rst-op wbRegWrite", 64'(wbRegWrite), 64'd0);
        chk("rst-op forwardOut", 64'(forwardOut), 64'd0);
        validIn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst wbValid %0d", k), 64'(wbValid), 64'd0);
            chk($sformatf("post-rst memWe %0d", k), 64'(memWe), 64'd0);
        end
        chk("rst-op mem lane0 written", 64'(mem[16'h0040]), 64'h0000AA);
        chk("rst-op mem lane1 untouched", 64'(mem[16'h0041]), 64'h123456);

        run_vec(vecs[8], 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vect_mem_stage.md
VECT_MEM_STAGE -- requirements
Module: vect_mem_stage

Interface
REQ-001 Parameter N, default 24, lane width in bits.
REQ-002 Parameter LANES, default 2, vector lanes per register.
REQ-003 Parameter ADDR_W, default 16, data-memory word address width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 validIn  in  1  execute-stage result valid this cycle.
REQ-007 memWrite  in  1  vector store.
REQ-008 memToReg  in  1  vector load.
REQ-009 regWrite  in  1  writeback enable for the instruction.
REQ-010 rdIn  in  4  destination vector register.
REQ-011 aluResult  in  LANES*N  ALU output from execute; also base address in lane 0 bits [ADDR_W-1:0].
REQ-012 storeData  in  LANES*N  RD3Out from execute; store payload, lane i at bits [i*N+N-1:i*N].
REQ-013 stall  out  1  upstream shall hold all inputs while high.
REQ-014 memAddr  out  ADDR_W  data-memory word address.
REQ-015 memWe  out  1  data-memory write strobe.
REQ-016 memWdata  out  N  data-memory write lane.
REQ-017 memRdata  in  N  synchronous read data; valid the cycle after its address.
REQ-018 wbValid  out  1  one-cycle pulse; writeback bundle valid.
REQ-019 wbRegWrite  out  1  registered regWrite, forced 0 for stores.
REQ-020 wbRd  out  4  registered destination.
REQ-021 wbData  out  LANES*N  loaded vector or passed ALU result.
REQ-022 forwardOut  out  LANES*N  equals wbData; feeds execute Forward1/2/3.

Function
REQ-023 States: IDLE, ACCESS, FINISH; lane counter idx, width clog2(LANES).
REQ-024 IDLE, validIn=1, memWrite=0, memToReg=0 -> pass-through: next edge registers wbData=aluResult, wbRd, wbRegWrite, wbValid=1; state stays IDLE; stall stays 0.
REQ-025 IDLE, validIn=1, memWrite or memToReg -> capture base, storeData, rdIn, flags; idx=0; go ACCESS; no wbValid.
REQ-026 stall = (state != IDLE), combinational.
REQ-027 ACCESS: memAddr = base + idx, modulo 2^ADDR_W (wraps 0xFFFF -> 0x0000).
REQ-028 ACCESS store: memWe=1, memWdata = captured lane idx; ACCESS load: memWe=0.
REQ-029 ACCESS, cycle with idx>=1, load: memRdata captured into lane idx-1 of wbData.
REQ-030 ACCESS, idx=LANES-1 -> FINISH; otherwise idx increments.
REQ-031 FINISH: memWe=0; load captures memRdata into lane LANES-1; next edge pulses wbValid=1, go IDLE.
REQ-032 Store: wbRegWrite=0, wbData unchanged from previous value.
REQ-033 memWrite and memToReg both 1 -> treated as store only.
REQ-034 Memory-op latency: accept edge E0, wbValid high in the cycle after edge E0+LANES+1; stall high for LANES+1 cycles.
REQ-035 validIn while stall=1 ignored (upstream holding the same instruction).
REQ-036 Back-to-back: a validIn in the first IDLE cycle after FINISH is accepted.
REQ-037 Outside ACCESS: memAddr=0, memWe=0, memWdata=0.
REQ-038 wbValid is high only in the single cycle following its registering edge.

Reset
REQ-039 rst=0, at any time including mid-ACCESS, immediately forces state=IDLE, idx=0, stall=0, memWe=0, memAddr=0, memWdata=0, wbValid=0, wbRegWrite=0, wbRd=0, wbData=0.
REQ-040 Interrupted memory op discarded: no wbValid after reset release; partial store lanes not repeated.

Verification
REQ-041 Pass-through: aluResult={24'd2,24'd1}, regWrite=1, rdIn=3 -> next cycle wbValid=1, wbData={2,1}, wbRd=3, stall never high.
REQ-042 Load: base 0x0010, memory[0x10]=11, [0x11]=12 -> memAddr 0x10, 0x11 on successive cycles, stall 3 cycles, wbData={12,11}, wbRegWrite=1.
REQ-043 Store: base 0x0020, storeData={10,9} -> memWe=1 with (0x20,9) then (0x21,10); wbValid=1 with wbRegWrite=0.
REQ-044 Wrap: load at base 0xFFFF -> addresses 0xFFFF then 0x0000.
REQ-045 Reset mid-op: assert rst in lane-1 cycle of a store -> memWe=0 at once, all outputs zero, no wbValid after release.
REQ-046 Back-to-back: load then pass-through held under stall -> pass-through wbValid one cycle after load wbValid, data correct for each.
